jts18_vdp_mix: RTL

- Final colour stage of the System 18 video path. It sits directly downstream of the VDP/System 16 priority stage and consumes its registered vdp_sel decision.
- The Genesis‑type VDP produces pixels on its own enable (vdp_cen), which is not phase‑locked to the S16 pixel enable. This block buffers VDP pixels in a per‑line FIFO and re‑times them to pxl_cen.
- Each pixel it selects either the VDP colour or the S16 palette colour and outputs registered RGB 5:5:5 with aligned blanking.

---
 rtl/jts18_vdp_mix.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/jts18_vdp_mix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jts18_vdp_mix                                                   |
// | Purpose  : System 18 final colour stage. Re-times VDP pixels to the S16    |
// |            pixel enable through a per-line FIFO. Muxes VDP/S16 colour into |
// |            registered RGB 5:5:5 with aligned blanking.                     |
// | Options  : JTS18_VDP_DEBUG_EN enables debug_bus colour overrides.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module jts18_vdp_mix #(
    parameter int AW      = 4,
    parameter int PREFILL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        vdp_cen,
    input  logic        vdp_hs,
    input  logic        vdp_de,
    input  logic [8:0]  vdp_rgb,
    input  logic        vdp_en,
    input  logic        hs,
    input  logic        lhbl,
    input  logic        lvbl,
    input  logic [14:0] s16_rgb,
    input  logic        vdp_sel,
    input  logic [7:0]  debug_bus,
    output logic [4:0]  red,
    output logic [4:0]  green,
    output logic [4:0]  blue,
    output logic        lhbl_dly,
    output logic        lvbl_dly,
    output logic        ovf,
    output logic        unf
);

    localparam int CW    = AW + 1;
    localparam int DEPTH = 2 ** AW;

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            vdp_hs_q;
    logic            hs_q;
    logic [8:0]      last_q, last_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic [8:0]      s1_pix_q, s1_pix_d;
    logic [14:0]     s1_s16_q;
    logic            s1_lhbl_q;
    logic            s1_lvbl_q;

    logic [4:0]      red_q, red_d;
    logic [4:0]      green_q, green_d;
    logic [4:0]      blue_q, blue_d;
    logic            lhbl_dly_q;
    logic            lvbl_dly_q;

    logic            vdp_hs_rise;
    logic            hs_rise;
    logic            lhbl_rise;
    logic            lhbl_fall;
    logic            lvbl_rise;
    logic            full;
    logic            empty;
    logic            wr_req;
    logic            push;
    logic            pop_req;
    logic            pop_ok;
    logic            flush;
    logic            use_vdp;
    logic [AW-1:0]   wr_addr;
    logic [8:0]      rd_data;

    assign vdp_hs_rise = vdp_hs & ~vdp_hs_q;
    // Read-side edges are judged against the stage-1 copies, which advance on pxl_cen.
    assign hs_rise     = pxl_cen & hs & ~hs_q;
    assign lhbl_rise   = pxl_cen & lhbl & ~s1_lhbl_q;
    assign lhbl_fall   = pxl_cen & ~lhbl & s1_lhbl_q;
    assign lvbl_rise   = pxl_cen & lvbl & ~s1_lvbl_q;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign wr_req  = vdp_cen & vdp_de;
    assign push    = wr_req & ~full;
    assign pop_ok  = pop_req & ~empty;
    assign flush   = vdp_hs_rise | hs_rise;
    assign wr_addr = flush ? '0 : wr_ptr_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        pop_req = 1'b0;
        if (pxl_cen) begin
            if (hs_rise) begin
                state_d = ST_FILL;
            end else begin
                case (state_q)
                    ST_WAIT: state_d = ST_WAIT;
                    ST_FILL: begin
                        if ((count_q >= PREFILL_C) || lhbl_rise) begin
                            state_d = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        pop_req = lhbl;
                        if (lhbl_fall) begin
                            state_d = ST_WAIT;
                        end
                    end
                    default: state_d = ST_WAIT;
                endcase
            end
        end
    end

    // A flush discards every queued entry; a write landing on the same cycle
    // becomes the first entry of the new line.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = push ? PTR_ONE : '0;
            count_d  = push ? CNT_ONE : '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        last_d   = last_q;
        s1_pix_d = '0;
        if (pop_ok) begin
            last_d = rd_data;
        end
        if (pop_req) begin
            s1_pix_d = empty ? last_q : rd_data;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (lvbl_rise) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr_req && full) begin
            ovf_d = 1'b1;
        end
        if (pop_req && empty) begin
            unf_d = 1'b1;
        end
    end

`ifdef JTS18_VDP_DEBUG_EN
    logic unused_debug;
    assign unused_debug = ^debug_bus[7:2];
    always_comb begin
        use_vdp = vdp_sel & vdp_en;
        if (debug_bus[0]) begin
            use_vdp = 1'b0;
        end else if (debug_bus[1]) begin
            use_vdp = 1'b1;
        end
    end
`else
    logic unused_debug;
    assign unused_debug = ^debug_bus;
    assign use_vdp      = vdp_sel & vdp_en;
`endif

    // 3-bit VDP components widen by bit replication so full scale maps to 31.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (s1_lhbl_q && s1_lvbl_q) begin
            if (use_vdp) begin
                red_d   = {s1_pix_q[8:6], s1_pix_q[8:7]};
                green_d = {s1_pix_q[5:3], s1_pix_q[5:4]};
                blue_d  = {s1_pix_q[2:0], s1_pix_q[2:1]};
            end else begin
                red_d   = s1_s16_q[14:10];
                green_d = s1_s16_q[9:5];
                blue_d  = s1_s16_q[4:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_addr] <= vdp_rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            vdp_hs_q   <= 1'b0;
            hs_q       <= 1'b0;
            last_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            s1_pix_q   <= '0;
            s1_s16_q   <= '0;
            s1_lhbl_q  <= 1'b0;
            s1_lvbl_q  <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            lhbl_dly_q <= 1'b0;
            lvbl_dly_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vdp_hs_q <= vdp_hs;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            if (pxl_cen) begin
                hs_q       <= hs;
                s1_pix_q   <= s1_pix_d;
                s1_s16_q   <= s16_rgb;
                s1_lhbl_q  <= lhbl;
                s1_lvbl_q  <= lvbl;
                red_q      <= red_d;
                green_q    <= green_d;
                blue_q     <= blue_d;
                lhbl_dly_q <= s1_lhbl_q;
                lvbl_dly_q <= s1_lvbl_q;
            end
        end
    end

    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign lhbl_dly = lhbl_dly_q;
    assign lvbl_dly = lvbl_dly_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule
`default_nettype wire
